mag_stim_gen: RTL and testbench



---
 rtl/stim_pkg.sv | 44 ++++
 rtl/readback_checker.sv | 61 ++++++
 rtl/mag_stim_gen.sv | 170 +++++++++++++++++
 tb/tb_mag_stim_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types, constants and width helpers for the magnetometer stimulus generator.
package stim_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_HOLD  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [15:0] SYNC_WORD_DEF = 16'hAAA2;
   localparam logic [7:0]  FRAME_ID_DEF  = 8'h4D;
   localparam logic [15:0] FIXED_BASE    = 16'hAAAA;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form (bits 0,2,3,5)
   localparam logic [15:0] LFSR_TAPS     = 16'h002D;
   localparam logic [15:0] ERR_SAT       = 16'hFFFF;

   function automatic int unsigned frame_w(input int unsigned ch, input int unsigned sw,
                                           input int unsigned tsw);
      return 32 + ch * sw + tsw;
   endfunction

   function automatic int unsigned frame_bytes(input int unsigned ch, input int unsigned sw,
                                               input int unsigned tsw);
      return frame_w(ch, sw, tsw) / 8;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] s, input int unsigned n);
      logic [31:0] w;
      w = {s, s} << (n % 16);
      return w[31:16];
   endfunction

endpackage

// File: rtl/readback_checker.sv
// Compares SRAM readback bytes against the current frame, MSB byte first,
// tracking the expected byte index and a saturating mismatch count.
module readback_checker
   import stim_pkg::*;
#(
   parameter int unsigned FRAME_W = 104,
   parameter int unsigned PTR_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [FRAME_W-1:0] i_frame,
   input  logic               i_frame_load,
   input  logic [7:0]         i_d_read,
   input  logic               i_d_valid,
   input  logic               i_err_clr,
   output logic [PTR_W-1:0]   o_byte_ptr,
   output logic [15:0]        o_err_count
);

   localparam int unsigned FRAME_BYTES = FRAME_W / 8;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_BYTES - 1);

   logic [PTR_W-1:0] r_ptr;
   logic [15:0]      r_err;
   logic [7:0]       w_sel;
   logic             w_mismatch;

   always_comb begin
      w_sel = '0;
      for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
         if (r_ptr == PTR_W'(i)) w_sel = i_frame[FRAME_W-1-8*i -: 8];
      end
   end

   assign w_mismatch = i_d_valid && (w_sel != i_d_read);

   // A frame load restarts the pointer; the compare in that cycle still sees the old frame.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_frame_load) begin
         r_ptr <= '0;
      end else if (i_d_valid) begin
         r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err <= '0;
      end else if (i_err_clr) begin
         r_err <= '0;
      end else if (w_mismatch && (r_err != ERR_SAT)) begin
         r_err <= r_err + 1'b1;
      end
   end

   assign o_byte_ptr  = r_ptr;
   assign o_err_count = r_err;

endmodule

// File: rtl/mag_stim_gen.sv
// Magnetometer/Geiger stimulus generator: framed multi-channel records, byte-request
// pacing, emulated Geiger square wave and SRAM readback checking.
module mag_stim_gen
   import stim_pkg::*;
#(
   parameter int unsigned MAG_CHANNELS = 3,
   parameter int unsigned SAMPLE_W     = 16,
   parameter int unsigned TS_W         = 24,
   parameter int unsigned FRAME_PERIOD = 10,
   parameter int unsigned BYTE_PERIOD  = 32,
   parameter int unsigned GEIG_DIV     = 1,
   parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
   parameter logic [7:0]  FRAME_ID     = FRAME_ID_DEF
) (
   input  logic                                                     CLK,
   input  logic                                                     RESET,
   input  logic                                                     ENABLE,
   input  logic [1:0]                                               MODE,
   input  logic [TS_W-1:0]                                          TIMESTAMP,
   input  logic [7:0]                                               D_READ,
   input  logic                                                     D_VALID,
   input  logic                                                     ERR_CLR,
   output logic [frame_w(MAG_CHANNELS, SAMPLE_W, TS_W)-1:0]         MAG_DATA,
   output logic                                                     MAG_VALID,
   output logic                                                     GEIG_COUNTS,
   output logic                                                     NEXT_BYTE,
   output logic [15:0]                                              ERR_COUNT,
   output logic [$clog2(frame_bytes(MAG_CHANNELS, SAMPLE_W, TS_W))-1:0] BYTE_PTR
);

   localparam int unsigned FRAME_W = frame_w(MAG_CHANNELS, SAMPLE_W, TS_W);
   localparam int unsigned PTR_W   = $clog2(frame_bytes(MAG_CHANNELS, SAMPLE_W, TS_W));
   localparam int unsigned FCNT_W  = $clog2(FRAME_PERIOD);
   localparam int unsigned BCNT_W  = $clog2(BYTE_PERIOD);
   localparam int unsigned GCNT_W  = (GEIG_DIV > 1) ? $clog2(GEIG_DIV) : 1;
   localparam int unsigned CH_W    = MAG_CHANNELS * SAMPLE_W;

   state_e r_state, w_state_nxt;
   logic   w_active;

   logic [FCNT_W-1:0]   r_fcnt;
   logic [BCNT_W-1:0]   r_bcnt;
   logic [GCNT_W-1:0]   r_gcnt;
   logic                w_frame_tc, w_byte_tc, w_geig_tc, w_load;

   logic [7:0]          r_seq;
   logic [SAMPLE_W-1:0] r_base;
   logic [15:0]         r_lfsr;
   logic [SAMPLE_W-1:0] r_samp     [MAG_CHANNELS];
   logic [SAMPLE_W-1:0] w_samp_nxt [MAG_CHANNELS];
   logic [15:0]         w_fixed    [MAG_CHANNELS];
   logic [15:0]         w_rot      [MAG_CHANNELS];
   logic [CH_W-1:0]     w_chans;
   logic [FRAME_W-1:0]  w_frame_nxt;

   logic [FRAME_W-1:0]  r_mag_data;
   logic                r_mag_valid, r_next_byte, r_geig;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // The entry edge itself is not a RUN clock, so counters start from 0 on the first RUN edge.
   always_comb begin
      w_state_nxt = r_state;
      w_active    = 1'b0;
      case (r_state)
         ST_IDLE: if (ENABLE) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (!ENABLE) w_state_nxt = ST_IDLE;
            else         w_active    = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_frame_tc = (r_fcnt == FCNT_W'(FRAME_PERIOD - 1));
   assign w_byte_tc  = (r_bcnt == BCNT_W'(BYTE_PERIOD - 1));
   assign w_geig_tc  = (r_gcnt == GCNT_W'(GEIG_DIV - 1));
   assign w_load     = w_active && w_frame_tc;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_fcnt <= '0;
         r_bcnt <= '0;
         r_gcnt <= '0;
      end else if (!w_active) begin
         r_fcnt <= '0;
         r_bcnt <= '0;
         r_gcnt <= '0;
      end else begin
         r_fcnt <= w_frame_tc ? '0 : r_fcnt + 1'b1;
         r_bcnt <= w_byte_tc  ? '0 : r_bcnt + 1'b1;
         r_gcnt <= w_geig_tc  ? '0 : r_gcnt + 1'b1;
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < MAG_CHANNELS; c++) begin
         w_fixed[c]    = FIXED_BASE ^ 16'(c);
         w_rot[c]      = rotl16(r_lfsr, c);
         w_samp_nxt[c] = r_samp[c];
         case (mode_e'(MODE))
            MODE_FIXED: w_samp_nxt[c] = w_fixed[c][SAMPLE_W-1:0];
            MODE_RAMP:  w_samp_nxt[c] = r_base + SAMPLE_W'(c);
            MODE_LFSR:  w_samp_nxt[c] = w_rot[c][SAMPLE_W-1:0];
            default:    w_samp_nxt[c] = r_samp[c];
         endcase
      end
   end

   always_comb begin
      w_chans = '0;
      for (int unsigned c = 0; c < MAG_CHANNELS; c++) begin
         w_chans[c*SAMPLE_W +: SAMPLE_W] = w_samp_nxt[c];
      end
   end

   assign w_frame_nxt = {SYNC_WORD, r_seq, w_chans, TIMESTAMP, FRAME_ID};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mag_data <= '0;
         r_seq      <= '0;
         r_base     <= '0;
         r_lfsr     <= LFSR_SEED;
         r_samp     <= '{default: '0};
      end else if (w_load) begin
         r_mag_data <= w_frame_nxt;
         r_seq      <= r_seq + 1'b1;
         r_samp     <= w_samp_nxt;
         if (mode_e'(MODE) == MODE_RAMP) r_base <= r_base + 1'b1;
         if (mode_e'(MODE) == MODE_LFSR) r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mag_valid <= 1'b0;
         r_next_byte <= 1'b0;
         r_geig      <= 1'b0;
      end else begin
         r_mag_valid <= w_load;
         r_next_byte <= w_active && w_byte_tc;
         if (w_active && w_geig_tc) r_geig <= ~r_geig;
      end
   end

   readback_checker #(
      .FRAME_W (FRAME_W),
      .PTR_W   (PTR_W)
   ) u_checker (
      .i_clk        (CLK),
      .i_rst        (RESET),
      .i_frame      (r_mag_data),
      .i_frame_load (w_load),
      .i_d_read     (D_READ),
      .i_d_valid    (D_VALID),
      .i_err_clr    (ERR_CLR),
      .o_byte_ptr   (BYTE_PTR),
      .o_err_count  (ERR_COUNT)
   );

   assign MAG_DATA    = r_mag_data;
   assign MAG_VALID   = r_mag_valid;
   assign NEXT_BYTE   = r_next_byte;
   assign GEIG_COUNTS = r_geig;

endmodule

// File: tb/tb_mag_stim_gen.sv
// Directed bench for mag_stim_gen with hand-computed expected frames and counters.
module tb_mag_stim_gen;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         ENABLE;
   logic [1:0]   MODE;
   logic [23:0]  TIMESTAMP;
   logic [7:0]   D_READ;
   logic         D_VALID;
   logic         ERR_CLR;
   logic [103:0] MAG_DATA;
   logic         MAG_VALID;
   logic         GEIG_COUNTS;
   logic         NEXT_BYTE;
   logic [15:0]  ERR_COUNT;
   logic [3:0]   BYTE_PTR;

   int checks = 0;
   int errors = 0;
   logic [103:0] exp_frame;
   logic [7:0]   exp_byte;

   always #5 CLK = ~CLK;

   mag_stim_gen #(
      .MAG_CHANNELS (3),
      .SAMPLE_W     (16),
      .TS_W         (24),
      .FRAME_PERIOD (10),
      .BYTE_PERIOD  (32),
      .GEIG_DIV     (1),
      .SYNC_WORD    (16'hAAA2),
      .FRAME_ID     (8'h4D)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ENABLE      (ENABLE),
      .MODE        (MODE),
      .TIMESTAMP   (TIMESTAMP),
      .D_READ      (D_READ),
      .D_VALID     (D_VALID),
      .ERR_CLR     (ERR_CLR),
      .MAG_DATA    (MAG_DATA),
      .MAG_VALID   (MAG_VALID),
      .GEIG_COUNTS (GEIG_COUNTS),
      .NEXT_BYTE   (NEXT_BYTE),
      .ERR_COUNT   (ERR_COUNT),
      .BYTE_PTR    (BYTE_PTR)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkf(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b0; MODE = 2'd0; TIMESTAMP = '0;
      D_READ = '0; D_VALID = 1'b0; ERR_CLR = 1'b0;
      tick(2);
      chkf ("rst_data",  MAG_DATA, '0);
      chk1 ("rst_valid", MAG_VALID, 1'b0);
      chk1 ("rst_geig",  GEIG_COUNTS, 1'b0);
      chk1 ("rst_nbyte", NEXT_BYTE, 1'b0);
      chk16("rst_err",   ERR_COUNT, 16'h0000);
      chk16("rst_ptr",   16'(BYTE_PTR), 16'h0000);

      // Fixed pattern run
      RESET = 1'b0; MODE = 2'd0; TIMESTAMP = 24'h123456; ENABLE = 1'b1;
      tick(10);
      chk1 ("f0_early", MAG_VALID, 1'b0);
      tick(1);
      chk1 ("f0_valid", MAG_VALID, 1'b1);
      chkf ("f0_data",  MAG_DATA, 104'hAAA2_00_AAA8_AAAB_AAAA_123456_4D);
      tick(1);
      chk1 ("f0_pulse_end", MAG_VALID, 1'b0);
      chk1 ("geig_e11", GEIG_COUNTS, 1'b1);
      tick(9);
      chk1 ("f1_valid", MAG_VALID, 1'b1);
      chkf ("f1_data",  MAG_DATA, 104'hAAA2_01_AAA8_AAAB_AAAA_123456_4D);
      tick(11);
      chk1 ("nb_early", NEXT_BYTE, 1'b0);
      tick(1);
      chk1 ("nb_first", NEXT_BYTE, 1'b1);
      tick(1);
      chk1 ("nb_end",   NEXT_BYTE, 1'b0);
      tick(31);
      chk1 ("nb_second", NEXT_BYTE, 1'b1);
      tick(1);
      ENABLE = 1'b0;
      tick(5);
      chk1 ("idle_geig_frozen", GEIG_COUNTS, 1'b1);
      chk1 ("idle_no_valid",    MAG_VALID, 1'b0);
      chkf ("idle_data_hold",   MAG_DATA, 104'hAAA2_05_AAA8_AAAB_AAAA_123456_4D);

      // Readback of the held frame with byte 5 corrupted
      exp_frame = 104'hAAA2_05_AAA8_AAAB_AAAA_123456_4D;
      for (int i = 0; i < 13; i++) begin
         exp_byte = exp_frame[103-8*i -: 8];
         D_READ   = (i == 5) ? ~exp_byte : exp_byte;
         D_VALID  = 1'b1;
         tick(1);
      end
      chk16("rb_err_one", ERR_COUNT, 16'd1);
      chk16("rb_ptr_wrap", 16'(BYTE_PTR), 16'd0);

      D_READ = 8'h00;
      tick(100);
      chk16("err_101", ERR_COUNT, 16'd101);
      tick(69900);
      chk16("err_sat", ERR_COUNT, 16'hFFFF);
      ERR_CLR = 1'b1;
      tick(1);
      chk16("err_clr_wins", ERR_COUNT, 16'h0000);
      chk16("ptr_after_clr", 16'(BYTE_PTR), 16'd9);
      ERR_CLR = 1'b0; D_VALID = 1'b0;

      // Partial frame discarded, then full period after re-entry
      ENABLE = 1'b1;
      tick(7);
      ENABLE = 1'b0;
      tick(6);
      chk1 ("partial_no_valid", MAG_VALID, 1'b0);
      chkf ("partial_hold",     MAG_DATA, 104'hAAA2_05_AAA8_AAAB_AAAA_123456_4D);
      ENABLE = 1'b1; TIMESTAMP = 24'hABCDEF;
      tick(10);
      chk1 ("reentry_early", MAG_VALID, 1'b0);
      D_VALID = 1'b1; D_READ = 8'h00;
      tick(1);
      chk1 ("reentry_valid", MAG_VALID, 1'b1);
      chkf ("reentry_data",  MAG_DATA, 104'hAAA2_06_AAA8_AAAB_AAAA_ABCDEF_4D);
      chk16("load_dv_err",   ERR_COUNT, 16'd1);
      chk16("load_dv_ptr",   16'(BYTE_PTR), 16'd0);
      D_VALID = 1'b0;

      // Asynchronous reset mid-frame
      tick(3);
      RESET = 1'b1;
      #1;
      chkf ("arst_data", MAG_DATA, '0);
      chk16("arst_err",  ERR_COUNT, 16'h0000);
      chk1 ("arst_geig", GEIG_COUNTS, 1'b0);
      tick(1);
      RESET = 1'b0; MODE = 2'd1; TIMESTAMP = 24'h000777; ENABLE = 1'b1;

      // Ramp, hold, then LFSR
      tick(11);
      chkf ("ramp0", MAG_DATA, 104'hAAA2_00_0002_0001_0000_000777_4D);
      tick(10);
      chkf ("ramp1", MAG_DATA, 104'hAAA2_01_0003_0002_0001_000777_4D);
      tick(10);
      chkf ("ramp2", MAG_DATA, 104'hAAA2_02_0004_0003_0002_000777_4D);
      MODE = 2'd3;
      tick(10);
      chkf ("hold3", MAG_DATA, 104'hAAA2_03_0004_0003_0002_000777_4D);
      MODE = 2'd2;
      tick(10);
      chkf ("lfsr0", MAG_DATA, 104'hAAA2_04_B386_59C3_ACE1_000777_4D);
      tick(10);
      chkf ("lfsr1", MAG_DATA, 104'hAAA2_05_59C1_ACE0_5670_000777_4D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
